c432_key_loader: RTL and testbench

// - Upstream stage for the locked c432 netlist: receives a 24-bit key serially and drives it onto keyinput0..keyinput23.
// - The key lands in a shadow register. It is committed to the outputs in one atomic step, so the locked core never sees a half-written key.
// - key_valid qualifies the key, and therefore the core's outputs, for the downstream oracle/compare logic.

---
 rtl/c432_key_loader.sv | 196 +++++++++++++++++++
 tb/tb_c432_key_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/c432_key_loader.sv
`default_nettype none
// ============================================================================
// Module   : c432_key_loader
// Purpose  : Serial-in key loader for the locked c432 netlist. Key bits are
//            collected LSB first into a shadow register and committed to
//            key_out (keyinput0..KEY_W-1) in a single atomic step, so the
//            locked core never sees a partially written key.
// Ports    : clk, rst          - clock / synchronous active-high reset
//            load_start        - 1-cycle pulse, begin or restart a key load
//            sdata_valid/sdata - serial key bit stream (LSB first)
//            sdata_ready       - loader accepts a bit this cycle
//            key_out           - committed key
//            key_valid         - key_out holds a complete committed key
//            busy              - load in progress
//            load_err          - sticky: last load rejected on parity
// Config   : KEY_PARITY_EN - when defined, one trailing even-parity bit is
//            required per load; otherwise load_err is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module c432_key_loader #(
    parameter int KEY_W = 24,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             sdata_valid,
    input  logic             sdata,
    output logic             sdata_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             load_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef KEY_PARITY_EN
        ST_PARITY = 2'd3,
`endif
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [KEY_W-1:0]   r_shadow;
    logic [KEY_W-1:0]   r_key;
    logic               r_key_valid;
    // A load_start seen during COMMIT is held here and acted on in IDLE.
    logic               r_start_pend;

    logic               w_ready;
    logic               w_start;
    logic               w_restart;
    logic               w_shift;
    logic               w_commit;
    logic               w_par_fail;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_start     = 1'b0;
        w_restart   = 1'b0;
        w_shift     = 1'b0;
        w_commit    = 1'b0;
        w_par_fail  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_start || r_start_pend) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_ready = 1'b1;
                // Restart wins over a bit presented in the same cycle.
                if (load_start) begin
                    w_restart = 1'b1;
                end else if (sdata_valid) begin
                    w_shift = 1'b1;
                    if (r_cnt == C_CNT_LAST) begin
`ifdef KEY_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_COMMIT;
`endif
                    end
                end
            end
`ifdef KEY_PARITY_EN
            ST_PARITY: begin
                w_ready = 1'b1;
                if (load_start) begin
                    w_restart   = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else if (sdata_valid) begin
                    // Even parity: key bits plus parity bit XOR to zero.
                    if (^{r_shadow, sdata}) begin
                        w_par_fail  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_COMMIT;
                    end
                end
            end
`endif
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_shadow     <= '0;
            r_key        <= '0;
            r_key_valid  <= 1'b0;
            r_start_pend <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt        <= '0;
                r_shadow     <= '0;
                r_key_valid  <= 1'b0;
                r_start_pend <= 1'b0;
            end
            if (w_restart) begin
                r_cnt    <= '0;
                r_shadow <= '0;
            end
            if (w_shift) begin
                r_shadow[r_cnt] <= sdata;
                r_cnt           <= r_cnt + C_CNT_ONE;
            end
            if (w_par_fail) begin
                r_shadow <= '0;
            end
            if (w_commit) begin
                r_key        <= r_shadow;
                r_key_valid  <= 1'b1;
                r_start_pend <= load_start;
            end
        end
    end

`ifdef KEY_PARITY_EN
    logic r_load_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_err <= 1'b0;
        end else if (w_start) begin
            r_load_err <= 1'b0;
        end else if (w_par_fail) begin
            r_load_err <= 1'b1;
        end
    end

    assign load_err = r_load_err;
`else
    assign load_err = 1'b0;
`endif

    assign sdata_ready = w_ready;
    assign key_out     = r_key;
    assign key_valid   = r_key_valid;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_c432_key_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_c432_key_loader
// Purpose  : Self-checking bench for c432_key_loader. A table of key loads
//            is applied in a loop, followed by hand-written sequences for
//            restart, reset mid-load, load_start during COMMIT and (with
//            KEY_PARITY_EN) parity acceptance / rejection.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c432_key_loader;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic        sdata_valid;
    logic        sdata;
    logic        sdata_ready;
    logic [23:0] key_out;
    logic        key_valid;
    logic        busy;
    logic        load_err;

    int total;
    int bad;
    int busy_drops;

    c432_key_loader #(
        .KEY_W(24),
        .CNT_W(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .sdata_valid(sdata_valid),
        .sdata      (sdata),
        .sdata_ready(sdata_ready),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .busy       (busy),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] key;
        bit          stall;
        logic        par;
        logic [23:0] exp_key;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_key(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_bits(input logic [23:0] key, input int nbits, input bit stall);
        logic [23:0] k;
        k = key;
        for (int i = 0; i < nbits; i++) begin
            if (stall) begin
                sdata_valid = 1'b0;
                sdata       = ~k[i];
                tick();
                if (!busy) busy_drops++;
            end
            sdata_valid = 1'b1;
            sdata       = k[i];
            tick();
            if (!busy) busy_drops++;
        end
        sdata_valid = 1'b0;
        sdata       = 1'b0;
    endtask

    // Full key plus, when the parity feature is built in, its parity bit.
    task automatic send_key(input logic [23:0] key, input bit stall, input logic par);
        send_bits(key, 24, stall);
`ifdef KEY_PARITY_EN
        sdata_valid = 1'b1;
        sdata       = par;
        tick();
        sdata_valid = 1'b0;
        sdata       = 1'b0;
`else
        if (par === 1'bx) busy_drops++;
`endif
    endtask

    // Called in the COMMIT cycle: key_valid must appear one edge later.
    task automatic finish_load(input string name, input logic [23:0] exp);
        chk_bit({name, "_kv_in_commit"}, key_valid, 1'b0);
        chk_bit({name, "_busy_in_commit"}, busy, 1'b1);
        tick();
        chk_bit({name, "_key_valid"}, key_valid, 1'b1);
        chk_bit({name, "_busy_done"}, busy, 1'b0);
        chk_key({name, "_key_out"}, key_out, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] prev_key;
        total       = 0;
        bad         = 0;
        busy_drops  = 0;
        rst         = 1'b1;
        load_start  = 1'b0;
        sdata_valid = 1'b0;
        sdata       = 1'b0;

        // key, stall, even-parity bit, expected key_out
        vecs[0] = '{24'hA5C30F, 1'b0, 1'b0, 24'hA5C30F};
        vecs[1] = '{24'hA5C30F, 1'b1, 1'b0, 24'hA5C30F};
        vecs[2] = '{24'h000001, 1'b0, 1'b1, 24'h000001};
        vecs[3] = '{24'h800000, 1'b1, 1'b1, 24'h800000};
        vecs[4] = '{24'h123456, 1'b1, 1'b1, 24'h123456};
        vecs[5] = '{24'hFFFFFF, 1'b0, 1'b0, 24'hFFFFFF};

        // ---------------- reset ----------------
        tick();
        tick();
        rst = 1'b0;
        chk_key("rst_key_out", key_out, 24'h000000);
        chk_bit("rst_key_valid", key_valid, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_sdata_ready", sdata_ready, 1'b0);
        chk_bit("rst_load_err", load_err, 1'b0);

        // ---------------- table-driven loads ----------------
        prev_key = 24'h000000;
        for (int v = 0; v < 6; v++) begin
            start_load();
            chk_bit($sformatf("v%0d_kv_cleared", v), key_valid, 1'b0);
            chk_key($sformatf("v%0d_key_held", v), key_out, prev_key);
            chk_bit($sformatf("v%0d_ready", v), sdata_ready, 1'b1);
            busy_drops = 0;
            send_key(vecs[v].key, vecs[v].stall, vecs[v].par);
            chk_bit($sformatf("v%0d_busy_thru", v), busy_drops == 0, 1'b1);
            finish_load($sformatf("v%0d", v), vecs[v].exp_key);
            chk_bit($sformatf("v%0d_load_err", v), load_err, 1'b0);
            prev_key = vecs[v].exp_key;
        end

        // ---------------- sdata ignored in IDLE ----------------
        sdata_valid = 1'b1;
        sdata       = 1'b0;
        tick();
        chk_bit("idle_ready", sdata_ready, 1'b0);
        tick();
        sdata_valid = 1'b0;
        chk_key("idle_key_out", key_out, 24'hFFFFFF);
        chk_bit("idle_busy", busy, 1'b0);

        // ---------------- reset mid-load after FFFFFF commit ----------------
        start_load();
        send_bits(24'h000000, 12, 1'b0);
        chk_bit("midrst_busy_before", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_key("midrst_key_out", key_out, 24'h000000);
        chk_bit("midrst_key_valid", key_valid, 1'b0);
        chk_bit("midrst_busy", busy, 1'b0);
        chk_bit("midrst_ready", sdata_ready, 1'b0);

        // ---------------- restart after 10 bits ----------------
        start_load();
        send_bits(24'hFFFFFF, 10, 1'b0);
        load_start  = 1'b1;
        sdata_valid = 1'b1;
        sdata       = 1'b1;     // dropped by the restart
        tick();
        load_start  = 1'b0;
        sdata_valid = 1'b0;
        chk_bit("restart_busy", busy, 1'b1);
        send_key(24'h123456, 1'b0, 1'b1);
        finish_load("restart", 24'h123456);

        // ---------------- load_start during COMMIT ----------------
        start_load();
        send_key(24'h0F0F0F, 1'b0, 1'b0);
        chk_bit("cst_busy_commit", busy, 1'b1);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk_bit("cst_kv_committed", key_valid, 1'b1);
        chk_key("cst_key_out", key_out, 24'h0F0F0F);
        tick();
        chk_bit("cst_kv_dropped", key_valid, 1'b0);
        chk_bit("cst_busy_again", busy, 1'b1);
        chk_key("cst_key_kept", key_out, 24'h0F0F0F);
        send_key(24'h000001, 1'b0, 1'b1);
        finish_load("cst_next", 24'h000001);

`ifdef KEY_PARITY_EN
        // ---------------- parity rejection ----------------
        start_load();
        send_key(24'hA5C30F, 1'b0, 1'b1);
        chk_bit("par_bad_load_err", load_err, 1'b1);
        chk_bit("par_bad_key_valid", key_valid, 1'b0);
        chk_bit("par_bad_busy", busy, 1'b0);
        chk_key("par_bad_key_out", key_out, 24'h000001);
        tick();
        chk_bit("par_bad_sticky", load_err, 1'b1);

        // ---------------- parity acceptance clears load_err ----------------
        start_load();
        chk_bit("par_start_clr", load_err, 1'b0);
        send_key(24'hA5C30F, 1'b0, 1'b0);
        finish_load("par_good", 24'hA5C30F);
        chk_bit("par_good_load_err", load_err, 1'b0);
`else
        chk_bit("noparity_load_err", load_err, 1'b0);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
